spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

SPI slave receiver that accepts 16-bit words from the SoC SPI master: CPOL=0, CPHA=0, MSB first, chip select active-low. It sits on the peripheral side of the SPI link. It oversamples `spi_cs`, `spi_sclk` and `spi_data` on the local `clk` and hands each completed word to the local logic through a valid/ready handshake. A return path to the master (MISO) can optionally be compiled in.

## Interface
Parameters:
- `WIDTH`, 16: bits per word.
- `SYNC_STAGES`, 2: flip-flop stages on each SPI input; legal range 2 to 3.

Ports:
- `clk`  in  1  system clock; every register is clocked on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `spi_cs`  in  1  chip select from the master, active-low.
- `spi_sclk`  in  1  serial clock from the master.
- `spi_data`  in  1  serial data from the master (MOSI).
- `rx_data`  out  WIDTH  last accepted word.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid` and `rx_ready` are both high.
- `overrun`  out  1  sticky flag: a word was dropped.
- `frame_err`  out  1  one-cycle pulse: the frame ended on a partial word.
- `tx_data`  in  WIDTH  word to return to the master (used only with MISO).
- `spi_miso`  out  1  serial data to the master.

## Operation
- Input synchronisation:
  - Each SPI input passes through `SYNC_STAGES` flip-flops.
  - Synchronised `cs`, `sclk` and `data` are mutually aligned.
  - One extra register holds the previous `sclk` and `cs` values for edge detection: rise = cur & ~prev, fall = ~cur & prev.
- State machine:
  - IDLE:
    - Waits for a falling edge on synchronised `cs`.
    - On that edge: go to RECV, `bit_cnt`=0.
  - RECV:
    - On each `sclk` rise: shift the synchronised data bit into the LSB of `shreg` (left shift, MSB first) and increment `bit_cnt`.
    - When the shift brings `bit_cnt` to WIDTH, the word completes and `bit_cnt` wraps to 0. The master may continue clocking without raising `cs`; back-to-back words are supported.
    - On a `cs` rise: go to IDLE. If `bit_cnt`≠0, pulse `frame_err` for one cycle and discard the partial word.
- Word delivery when a word completes:
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in the same cycle: `rx_data`←word and `rx_valid`←1.
  - Otherwise: the word is dropped, `rx_data` is unchanged, and `overrun`←1.
  - A handshake with no new word completing clears `rx_valid`.
  - `overrun` clears only on reset.
- A `sclk` edge that coincides with the `cs` rise is ignored; the `cs` rise takes priority.
- The `sclk` level at the `cs` fall is ignored; only edges seen while in RECV count.

## Timing
- Reset values:
  - Outputs: `rx_data`=0, `rx_valid`=0, `overrun`=0, `frame_err`=0, `spi_miso`=0.
  - Internal: state IDLE, `bit_cnt`=0, synchronisers preloaded to cs=1, sclk=0, data=0.
- Latency:
  - `rx_valid` rises exactly SYNC_STAGES+1 `clk` edges after the pin-level `sclk` rise for the last bit.
  - `frame_err` rises SYNC_STAGES+1 edges after the pin-level `cs` rise.
- Input rate requirement: `sclk` high and low phases must each last ≥2 `clk` periods, i.e. f_sclk ≤ f_clk/4. `spi_data` must be stable for ≥2 `clk` periods around each `sclk` rise.
- Reset mid-frame: the frame is abandoned. After reset deasserts the block stays in IDLE until a fresh `cs` fall, so a `cs` already low at reset release does not start a frame.
- `rx_data` is stable while `rx_valid`=1 and no handshake occurs.

## Configuration
- Macro: `SPI_SLAVE_MISO_EN`.
- With the macro defined:
  - On the synchronised `cs` fall, `tx_data` is latched into `tx_shreg`.
  - `spi_miso` = `tx_shreg[WIDTH-1]`.
  - On each synchronised `sclk` fall, `tx_shreg` shifts left, filling with 0.
  - After a word completes in RECV, `tx_data` is reloaded on the next `sclk` fall instead of shifting.
  - In IDLE, `spi_miso`=0.
- Without the macro:
  - `tx_shreg` is not built.
  - `spi_miso` is tied to 0 and `tx_data` is ignored.
  - The port list is unchanged.

## Test plan
- Single frame, `rx_ready`=1: `cs` low, send 16'hA5C3, `cs` high → one `rx_valid` pulse with `rx_data`=16'hA5C3 at SYNC_STAGES+1 clk after the 16th `sclk` rise; `frame_err`=0.
- Back-to-back, `rx_ready`=0: send 16'h1234 then 16'hBEEF under one `cs`-low period → `rx_data`=16'h1234, `overrun`=1; after `rx_ready` pulses, `rx_valid`=0 and `overrun` stays 1.
- Simultaneous handshake and completion: hold `rx_ready` high in the completion cycle of the second word → `rx_data`=16'hBEEF, `rx_valid` stays 1, `overrun`=0.
- Partial frame: 9 `sclk` rises then `cs` high → one-cycle `frame_err`, `rx_valid` stays 0; the next full frame 16'h00FF is received correctly.
- Reset mid-frame: assert `reset` after 5 bits with `cs` held low; release → all outputs 0 and no word is received until `cs` goes high then low again.
- MISO (macro defined): `tx_data`=16'h8001, 16-bit frame → master samples 1,0×14,1 on its `sclk` rises. Macro undefined → `spi_miso` is constant 0.

Source files
------------

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave receiver with valid/ready word output.
// Ports:
//   clk, reset (async, active-low)
//   spi_cs, spi_sclk, spi_data  : raw SPI pins, oversampled on clk
//   rx_data, rx_valid, rx_ready : received word handshake
//   overrun                     : sticky, a completed word was dropped
//   frame_err                   : one-cycle pulse, frame ended on a partial word
//   tx_data, spi_miso           : return path, active only with SPI_SLAVE_MISO_EN defined
// Build option: define SPI_SLAVE_MISO_EN to build the MISO shifter; otherwise spi_miso is tied low.
module spi_slave_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_cs,
    input  logic             spi_sclk,
    input  logic             spi_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    output logic             frame_err,
    input  logic [WIDTH-1:0] tx_data,
    output logic             spi_miso
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RECV} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, data_sync, flush;
    logic                   cs_prev, sclk_prev, armed;
    logic                   cs_cur, sclk_cur, data_cur;
    logic                   cs_rise, cs_fall, sclk_rise;
    logic                   start, shift, word_done, frame_err_nxt;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-2:0]       shreg;
    logic [WIDTH-1:0]       word;

    assign cs_cur    = cs_sync[SYNC_STAGES-1];
    assign sclk_cur  = sclk_sync[SYNC_STAGES-1];
    assign data_cur  = data_sync[SYNC_STAGES-1];
    assign cs_rise   = cs_cur & ~cs_prev;
    assign cs_fall   = ~cs_cur & cs_prev;
    assign sclk_rise = sclk_cur & ~sclk_prev;
    // armed only after a genuine high cs has been seen, so a cs held low across reset cannot start a frame
    assign start     = (state == IDLE) & cs_fall & armed;
    // a cs rise wins over any coincident sclk edge
    assign shift     = (state == RECV) & ~cs_rise & sclk_rise;
    assign word_done = shift & (bit_cnt == CW'(WIDTH - 1));
    assign word      = {shreg, data_cur};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        frame_err_nxt = 1'b0;
        if (start)
            state_nxt = RECV;
        if (state == RECV && cs_rise) begin
            state_nxt     = IDLE;
            frame_err_nxt = bit_cnt != '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            data_sync <= '0;
            flush     <= '0;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            cs_prev   <= cs_cur;
            sclk_prev <= sclk_cur;
            // flush marks when the synchroniser holds real pin samples rather than reset preloads
            flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
            armed     <= armed | (flush[SYNC_STAGES-1] & cs_cur);
            frame_err <= frame_err_nxt;
            if (start || (state == RECV && cs_rise))
                bit_cnt <= '0;
            else if (shift) begin
                shreg   <= word[WIDTH-2:0];
                bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
            end
            if (word_done && (!rx_valid || rx_ready)) begin
                rx_data  <= word;
                rx_valid <= 1'b1;
            end else if (word_done)
                overrun <= 1'b1;
            else if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_MISO_EN
    logic [WIDTH-1:0] tx_shreg;
    logic             tx_reload;
    logic             sclk_fall;

    assign sclk_fall = ~sclk_cur & sclk_prev;

    // after a word completes the next fall presents a fresh tx_data word instead of shifting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_shreg  <= '0;
            tx_reload <= 1'b0;
        end else if (start) begin
            tx_shreg  <= tx_data;
            tx_reload <= 1'b0;
        end else if (state == RECV && !cs_rise) begin
            if (word_done)
                tx_reload <= 1'b1;
            else if (sclk_fall) begin
                tx_shreg  <= tx_reload ? tx_data : {tx_shreg[WIDTH-2:0], 1'b0};
                tx_reload <= 1'b0;
            end
        end
    end

    assign spi_miso = (state == RECV) & tx_shreg[WIDTH-1];
`else
    logic unused_tx;

    assign unused_tx = ^tx_data;
    assign spi_miso  = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: scoreboard bench for spi_slave_rx; words expected by the consumer are queued when sent
// and compared on each rx_valid/rx_ready handshake.
module tb_spi_slave_rx;
    localparam int W  = 16;
    localparam int SS = 2;

    logic         clk = 1'b0, reset = 1'b0;
    logic         spi_cs = 1'b1, spi_sclk = 1'b0, spi_data = 1'b0, rx_ready = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic [W-1:0] rx_data;
    logic         rx_valid, overrun, frame_err, spi_miso;
    int           total = 0, bad = 0, fe_cnt = 0, miso_hi = 0, pops = 0, lat = 0, fe_lat = 0, fe0 = 0, pops0 = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] miso_w = '0;

    always #5 clk = ~clk;

    spi_slave_rx #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_data(spi_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
        .frame_err(frame_err), .tx_data(tx_data), .spi_miso(spi_miso)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (spi_miso) miso_hi++;
        if (reset && rx_valid && rx_ready) begin
            if (exp_q.size() == 0)
                check("sb_unexp", exp_q.size(), 1);
            else begin
                check("sb_word", rx_data, exp_q.pop_front());
                pops++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one bit: data set in the low phase, master samples miso at the rise
    task automatic send_bit(input logic b, input bit last_rdy);
        spi_data = b;
        tick(4);
        miso_w   = {miso_w[W-2:0], spi_miso};
        spi_sclk = 1'b1;
        lat      = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (rx_valid && lat == 0) lat = k;
            if (last_rdy && k == SS) rx_ready = 1'b1;
            if (last_rdy && k == SS + 1) rx_ready = 1'b0;
        end
        spi_sclk = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int n, input bit last_rdy);
        for (int i = W - 1; i >= W - n; i--)
            send_bit(w[i], last_rdy && i == W - n);
    endtask

    task automatic frame(input logic [W-1:0] w);
        spi_cs = 1'b0;
        tick(4);
        exp_q.push_back(w);
        send_word(w, W, 1'b0);
        tick(2);
        spi_cs = 1'b1;
        tick(6);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, rx_data, 0);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_miso"}, spi_miso, 0);
    endtask

    initial begin
        tick(3);
        check_idle_outputs("rst");
        reset = 1'b1;
        tick(5);

        rx_ready = 1'b1;
        frame(16'hA5C3);
        check("lat_valid", lat, SS + 1);
        check("t1_ferr", fe_cnt, 0);
        check("t1_valid", rx_valid, 0);

        rx_ready = 1'b0;
        spi_cs   = 1'b0;
        tick(4);
        exp_q.push_back(16'h1234);
        send_word(16'h1234, W, 1'b0);
        send_word(16'hBEEF, W, 1'b0);
        tick(2);
        spi_cs = 1'b1;
        tick(6);
        check("b2b_data", rx_data, 16'h1234);
        check("b2b_valid", rx_valid, 1);
        check("b2b_ovr", overrun, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("b2b_valid_clr", rx_valid, 0);
        check("b2b_ovr_sticky", overrun, 1);

        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(5);
        spi_cs = 1'b0;
        tick(4);
        exp_q.push_back(16'h1234);
        send_word(16'h1234, W, 1'b0);
        exp_q.push_back(16'hBEEF);
        send_word(16'hBEEF, W, 1'b1);
        tick(2);
        spi_cs = 1'b1;
        tick(6);
        check("sim_data", rx_data, 16'hBEEF);
        check("sim_valid", rx_valid, 1);
        check("sim_ovr", overrun, 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("sim_valid_clr", rx_valid, 0);

        fe0    = fe_cnt;
        spi_cs = 1'b0;
        tick(4);
        send_word(16'hFFFF, 9, 1'b0);
        tick(2);
        spi_cs = 1'b1;
        fe_lat = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (frame_err && fe_lat == 0) fe_lat = k;
        end
        check("fe_lat", fe_lat, SS + 1);
        check("fe_pulses", fe_cnt - fe0, 1);
        check("fe_valid", rx_valid, 0);
        rx_ready = 1'b1;
        frame(16'h00FF);

        spi_cs = 1'b0;
        tick(4);
        send_word(16'hFFFF, 5, 1'b0);
        reset = 1'b0;
        tick(3);
        check_idle_outputs("rstmid");
        reset = 1'b1;
        tick(5);
        check_idle_outputs("rel");
        pops0 = pops;
        fe0   = fe_cnt;
        send_word(16'hFFFF, W, 1'b0);
        tick(4);
        check("nostart_valid", rx_valid, 0);
        check("nostart_pops", pops, pops0);
        spi_cs = 1'b1;
        tick(6);
        check("nostart_ferr", fe_cnt, fe0);
        frame(16'h5A5A);

        tx_data = 16'h8001;
        frame(16'h3C3C);
`ifdef SPI_SLAVE_MISO_EN
        check("miso_word", miso_w, 16'h8001);
`else
        check("miso_word", miso_w, 0);
        check("miso_hi", miso_hi, 0);
`endif

        check("sb_left", exp_q.size(), 0);
        check("sb_pops", pops, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
